// File: rtl/bf2_1_sched.sv
// Block scheduler for the radix-2^2 stage-2_1 butterfly: credit-gated issue,
// sof/eof tag alignment with the butterfly output strobe, and frame-drain tracking.
module bf2_1_sched #(
  parameter int BLK_PER_FRAME = 32,
  parameter int LATENCY       = 2,
  parameter int CREDITS       = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             enable,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             valid_2_1,
  output logic [$clog2(BLK_PER_FRAME)-1:0] blk_idx,
  input  logic                             bf2_1_o_en,
  output logic                             out_valid,
  output logic                             out_sof,
  output logic                             out_eof,
  input  logic                             credit_ret,
  output logic                             frame_done,
  output logic                             busy,
  output logic                             err,
  output logic [1:0]                       dbg_state
);
  localparam int IDX_W   = $clog2(BLK_PER_FRAME);
  localparam int CRD_W   = $clog2(CREDITS + 1);
  localparam int INF_MAX = (LATENCY > CREDITS) ? LATENCY + 1 : CREDITS + 1;
  localparam int INF_W   = $clog2(INF_MAX + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [IDX_W-1:0] LAST_BLK = IDX_W'(BLK_PER_FRAME - 1);
  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(CREDITS);

  logic [1:0]         state, state_nxt;
  logic [IDX_W-1:0]   blk_cnt;
  logic [INF_W-1:0]   inflight, inflight_nxt;
  logic [CRD_W-1:0]   credit_cnt;
  logic [LATENCY-1:0] sof_pipe, eof_pipe;
  logic               accept, last_blk, oen_bad, cr_bad;

  // Handshake: a block moves when in_valid && in_ready in the same cycle; the
  // butterfly is strobed in that very cycle. frame_done blocks the restart cycle.
  assign in_ready  = rstn && enable && (credit_cnt != '0) && (state != DRAIN) && !frame_done;
  assign accept    = in_valid && in_ready;
  assign valid_2_1 = accept;
  assign blk_idx   = blk_cnt;
  assign last_blk  = (blk_cnt == LAST_BLK);

  assign out_valid = rstn && bf2_1_o_en;
  assign out_sof   = out_valid && sof_pipe[LATENCY-1];
  assign out_eof   = out_valid && eof_pipe[LATENCY-1];
  assign busy      = rstn && (state != IDLE);
  assign dbg_state = state;

  assign oen_bad = bf2_1_o_en && (inflight == '0);
  assign cr_bad  = credit_ret && (credit_cnt == CRD_FULL);

  always_comb begin
    inflight_nxt = inflight;
    if (accept && !bf2_1_o_en)
      inflight_nxt = inflight + INF_W'(1);
    else if (!accept && bf2_1_o_en && !oen_bad)
      inflight_nxt = inflight - INF_W'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RUN: if (accept) state_nxt = last_blk ? DRAIN : RUN;
      DRAIN:     if (inflight_nxt == '0) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      blk_cnt    <= '0;
      inflight   <= '0;
      credit_cnt <= CRD_FULL;
      sof_pipe   <= '0;
      eof_pipe   <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      inflight   <= inflight_nxt;
      frame_done <= (state == DRAIN) && (inflight_nxt == '0);
      err        <= err | oen_bad | cr_bad;

      if (accept)
        blk_cnt <= last_blk ? '0 : blk_cnt + IDX_W'(1);

      if (accept && !credit_ret)
        credit_cnt <= credit_cnt - CRD_W'(1);
      else if (!accept && credit_ret && !cr_bad)
        credit_cnt <= credit_cnt + CRD_W'(1);

      // Tags enter on accept and emerge exactly when bf2_1_o_en does.
      sof_pipe[0] <= accept && (blk_cnt == '0);
      eof_pipe[0] <= accept && last_blk;
      for (int i = 1; i < LATENCY; i++) begin
        sof_pipe[i] <= sof_pipe[i-1];
        eof_pipe[i] <= eof_pipe[i-1];
      end
    end
  end
endmodule

// File: tb/tb_bf2_1_sched.sv
// Directed bench for bf2_1_sched: 4-block frames, 2-cycle butterfly model, 2 credits.
module tb_bf2_1_sched;
  localparam int BLK = 4;
  localparam int LAT = 2;
  localparam int CRD = 2;
  localparam int NQ  = 1024;

  logic       clk = 1'b0;
  logic       rstn, enable, in_valid, bf2_1_o_en, credit_ret;
  logic       in_ready, valid_2_1, out_valid, out_sof, out_eof;
  logic       frame_done, busy, err;
  logic [1:0] blk_idx;
  logic [1:0] dbg_state;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         n_issue, n_out, fd_count;
  logic [15:0] sof_mask, eof_mask;
  bit         oen_q [NQ];
  bit         cr_q [NQ];
  bit         auto_bf, auto_cr, man_oen, man_cr;
  logic [1:0] exp_q[$];

  bf2_1_sched #(.BLK_PER_FRAME(BLK), .LATENCY(LAT), .CREDITS(CRD)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready), .valid_2_1(valid_2_1), .blk_idx(blk_idx),
    .bf2_1_o_en(bf2_1_o_en), .out_valid(out_valid), .out_sof(out_sof),
    .out_eof(out_eof), .credit_ret(credit_ret), .frame_done(frame_done),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < NQ; i++) begin
      oen_q[i] = 1'b0;
      cr_q[i]  = 1'b0;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; in_valid = 1'b0; enable = 1'b1;
    man_oen = 1'b0; man_cr = 1'b0; bf2_1_o_en = 1'b0; credit_ret = 1'b0;
    clear_sched();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    n_issue = 0; n_out = 0; fd_count = 0; sof_mask = '0; eof_mask = '0;
    exp_q.delete();
  endtask

  // One clock: drive inputs, sample at negedge, return at posedge+1.
  task automatic cycle();
    int idx;
    idx = cyc % NQ;
    bf2_1_o_en = man_oen || (auto_bf && oen_q[idx]);
    credit_ret = man_cr || (auto_cr && cr_q[idx]);
    @(negedge clk);
    if (valid_2_1) begin
      n_issue++;
      oen_q[(cyc + LAT) % NQ] = 1'b1;
      if (exp_q.size() == 0) check("issue_unexpected", 32'(exp_q.size()), 1);
      else check("issue_blk_idx", 32'(blk_idx), 32'(exp_q.pop_front()));
    end
    if (out_valid) begin
      if (n_out < 16) begin
        sof_mask[n_out] = out_sof;
        eof_mask[n_out] = out_eof;
      end
      n_out++;
      cr_q[(cyc + 2) % NQ] = 1'b1;
    end
    if (frame_done) fd_count++;
    @(posedge clk);
    #1;
    oen_q[idx] = 1'b0;
    cr_q[idx]  = 1'b0;
    cyc++;
  endtask

  task automatic push_frame(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back(2'(i));
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b1; in_valid = 1'b1; bf2_1_o_en = 1'b1; credit_ret = 1'b0;
    auto_bf = 1'b0; auto_cr = 1'b0; man_oen = 1'b0; man_cr = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_valid_2_1", valid_2_1, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_state", dbg_state, 0);
    do_reset();

    // Full frame with credits returned two cycles after each output.
    auto_bf = 1'b1; auto_cr = 1'b1;
    push_frame(0, 3);
    in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (n_issue >= 4) in_valid = 1'b0;
      cycle();
    end
    check("t1_issues", n_issue, 4);
    check("t1_outs", n_out, 4);
    check("t1_sof", sof_mask, 16'h0001);
    check("t1_eof", eof_mask, 16'h0008);
    check("t1_frame_done", fd_count, 1);
    check("t1_busy", busy, 0);
    check("t1_state", dbg_state, 0);
    check("t1_err", err, 0);
    check("t1_in_ready", in_ready, 1);
    check("t1_pending", exp_q.size(), 0);

    // Credit stall: two accepts, then one credit buys exactly one more.
    do_reset();
    auto_bf = 1'b1; auto_cr = 1'b0;
    push_frame(0, 1);
    in_valid = 1'b1;
    repeat (10) cycle();
    check("t2_issues_a", n_issue, 2);
    check("t2_in_ready_a", in_ready, 0);
    check("t2_state", dbg_state, 1);
    push_frame(2, 2);
    man_cr = 1'b1;
    cycle();
    man_cr = 1'b0;
    repeat (10) cycle();
    check("t2_issues_b", n_issue, 3);
    check("t2_in_ready_b", in_ready, 0);
    check("t2_pending", exp_q.size(), 0);
    check("t2_err", err, 0);

    // Accept and credit_ret in the same cycle with one credit left.
    do_reset();
    auto_bf = 1'b1; auto_cr = 1'b0;
    push_frame(0, 0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("t3_ready_one_credit", in_ready, 1);
    push_frame(1, 1);
    in_valid = 1'b1; man_cr = 1'b1;
    cycle();
    in_valid = 1'b0; man_cr = 1'b0;
    check("t3_issues_a", n_issue, 2);
    check("t3_ready_after_both", in_ready, 1);
    push_frame(2, 2);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("t3_issues_b", n_issue, 3);
    check("t3_ready_empty", in_ready, 0);
    repeat (4) cycle();
    check("t3_err", err, 0);
    check("t3_pending", exp_q.size(), 0);

    // Enable dropped after block 1 for ten cycles.
    do_reset();
    auto_bf = 1'b1; auto_cr = 1'b1;
    push_frame(0, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && n_issue < 2; i++) cycle();
    check("t4_issues_pre", n_issue, 2);
    enable = 1'b0;
    repeat (10) cycle();
    check("t4_window_issues", n_issue, 2);
    check("t4_state", dbg_state, 1);
    check("t4_busy", busy, 1);
    check("t4_in_ready", in_ready, 0);
    enable = 1'b1;
    push_frame(2, 3);
    for (int i = 0; i < 20 && n_issue < 3; i++) cycle();
    check("t4_resume_issue", n_issue, 3);
    for (int i = 0; i < 30; i++) begin
      if (n_issue >= 4) in_valid = 1'b0;
      cycle();
    end
    check("t4_frame_done", fd_count, 1);
    check("t4_sof", sof_mask, 16'h0001);
    check("t4_eof", eof_mask, 16'h0008);
    check("t4_busy_end", busy, 0);
    check("t4_err", err, 0);
    check("t4_pending", exp_q.size(), 0);

    // Spurious butterfly strobe while idle.
    do_reset();
    auto_bf = 1'b0; auto_cr = 1'b0;
    man_oen = 1'b1;
    cycle();
    man_oen = 1'b0;
    check("t5_err_set", err, 1);
    check("t5_state", dbg_state, 0);
    check("t5_busy", busy, 0);
    repeat (5) cycle();
    check("t5_err_sticky", err, 1);
    clear_sched();
    n_out = 0; sof_mask = '0; eof_mask = '0;
    auto_bf = 1'b1; auto_cr = 1'b1;
    push_frame(0, 3);
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (n_issue >= 4) in_valid = 1'b0;
      cycle();
    end
    check("t5_frame_done", fd_count, 1);
    check("t5_busy_end", busy, 0);
    check("t5_err_held", err, 1);
    check("t5_pending", exp_q.size(), 0);
    do_reset();
    check("t5_err_cleared", err, 0);

    // Asynchronous reset mid-frame after two issues.
    auto_bf = 1'b1; auto_cr = 1'b1;
    push_frame(0, 3);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && n_issue < 2; i++) cycle();
    check("t6_issues_pre", n_issue, 2);
    bf2_1_o_en = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("t6_in_ready", in_ready, 0);
    check("t6_valid_2_1", valid_2_1, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_out_sof", out_sof, 0);
    check("t6_out_eof", out_eof, 0);
    check("t6_busy", busy, 0);
    check("t6_state", dbg_state, 0);
    bf2_1_o_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_no_frame_done", frame_done, 0);
    check("t6_fd_count", fd_count, 0);
    do_reset();
    auto_bf = 1'b1; auto_cr = 1'b1;
    push_frame(0, 3);
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (n_issue >= 4) in_valid = 1'b0;
      cycle();
    end
    check("t6_issues", n_issue, 4);
    check("t6_sof", sof_mask, 16'h0001);
    check("t6_eof", eof_mask, 16'h0008);
    check("t6_frame_done", fd_count, 1);
    check("t6_err", err, 0);
    check("t6_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bf2_1_sched.md
BF2_1_SCHED -- requirements
Module: bf2_1_sched

Interface
REQ-001 SHALL have parameter BLK_PER_FRAME, default 32: 16-sample blocks per FFT frame (power of 2, >=2).
REQ-002 SHALL have parameter LATENCY, default 2: cycles from valid_2_1 to bf2_1_o_en in the stage-2_1 butterfly.
REQ-003 SHALL have parameter CREDITS, default 4: downstream block-buffer depth (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  level; 0 pauses acceptance without losing state.
REQ-007 SHALL have port in_valid  input  1  upstream block available.
REQ-008 SHALL have port in_ready  output  1  scheduler accepts block this cycle.
REQ-009 SHALL have port valid_2_1  output  1  issue strobe to the butterfly valid_2_1 input.
REQ-010 SHALL have port blk_idx  output  $clog2(BLK_PER_FRAME)  index of the block being issued (twiddle select).
REQ-011 SHALL have port bf2_1_o_en  input  1  butterfly output-valid strobe.
REQ-012 SHALL have port out_valid  output  1  block valid to downstream.
REQ-013 SHALL have port out_sof  output  1  first block of frame, qualified by out_valid.
REQ-014 SHALL have port out_eof  output  1  last block of frame, qualified by out_valid.
REQ-015 SHALL have port credit_ret  input  1  one-cycle pulse: downstream freed one block slot.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse when a frame fully drains.
REQ-017 SHALL have port busy  output  1  state != IDLE.
REQ-018 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-019 SHALL implement FSM IDLE, RUN, DRAIN.
REQ-020 SHALL drive in_ready = enable && credit_cnt>0 && state!=DRAIN (combinational); accept = in_valid && in_ready.
REQ-021 SHALL drive valid_2_1 = accept combinationally so butterfly samples din in the accept cycle; blk_idx = blk_cnt in the same cycle.
REQ-022 SHALL transition IDLE->RUN on accept; blk_cnt increments on each accept.
REQ-023 SHALL, on accept with blk_cnt==BLK_PER_FRAME-1, wrap blk_cnt to 0 and go to DRAIN next cycle.
REQ-024 SHALL in DRAIN hold in_ready=0 until inflight==0 (after counting that cycle's bf2_1_o_en), then go IDLE and pulse frame_done for one cycle.
REQ-025 SHALL keep inflight counter: +1 on accept, -1 on bf2_1_o_en, unchanged when both occur; width holds LATENCY+1.
REQ-026 SHALL keep credit_cnt: -1 on accept, +1 on credit_ret, unchanged when both occur; never exceeds CREDITS.
REQ-027 SHALL carry sof/eof tags through a LATENCY-deep shift register so tags align with bf2_1_o_en.
REQ-028 SHALL drive out_valid = bf2_1_o_en; out_sof/out_eof are the delayed tags, 0 when out_valid=0.
REQ-029 SHALL, for BLK_PER_FRAME blocks, assert out_sof on block 0 and out_eof on block BLK_PER_FRAME-1 only.
REQ-030 SHALL set err on bf2_1_o_en while inflight==0 (decrement suppressed) or credit_ret while credit_cnt==CREDITS (increment suppressed).
REQ-031 SHALL, when enable falls mid-frame, stop accepting, retain blk_cnt/state, continue counting bf2_1_o_en and credit_ret, resume at next index.
REQ-032 SHALL NOT start a new frame in the cycle frame_done pulses; earliest next accept is the following cycle.

Reset
REQ-033 SHALL on rstn=0 immediately clear: state=IDLE, blk_cnt=0, inflight=0, credit_cnt=CREDITS, tag pipe=0, err=0, frame_done=0.
REQ-034 SHALL hold in_ready, valid_2_1, out_valid, out_sof, out_eof, busy at 0 during reset; reset mid-frame discards the frame with no frame_done.

Verification
REQ-035 SHALL test full frame, BLK_PER_FRAME=4, in_valid held 1, credit_ret 2 cycles after each out_valid -> 4 issues blk_idx 0..3, out_sof at 1st, out_eof at 4th out_valid, frame_done once, busy low after.
REQ-036 SHALL test credit stall, CREDITS=2, no credit_ret -> exactly 2 accepts, in_ready=0; one credit_ret pulse -> exactly one more accept.
REQ-037 SHALL test simultaneous accept and credit_ret with credit_cnt=1 -> credit_cnt stays 1, in_ready stays 1.
REQ-038 SHALL test enable=0 after block 1 for 10 cycles -> no valid_2_1 in window, next issue has blk_idx=2.
REQ-039 SHALL test spurious bf2_1_o_en in IDLE -> err=1 and stays 1 until rstn low; inflight stays 0.
REQ-040 SHALL test rstn pulsed low mid-frame after 2 issues -> all outputs 0 asynchronously, next frame starts at blk_idx=0 with out_sof.
